gf256_inv_pipe: RTL and testbench

- Multi-lane, 3-stage pipelined GF(2^8) inversion and AES S-box engine built on the Canright tower-field decomposition GF(2^8)/GF(2^4)/GF(2^2) in normal basis.
- Sits between the round datapath and the SubBytes/key-expansion logic.
- Has a valid/ready handshake and full backpressure, so one instance can be shared by round and key-schedule traffic through the tag sideband.

---
 rtl/gf256_inv_pipe.sv | 198 +++++++++++++++++++
 tb/tb_gf256_inv_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf256_inv_pipe.sv
// gf256_inv_pipe: LANES-wide, 3-stage pipelined GF(2^8) inverter / AES S-box
// built on the Canright normal-basis tower GF(2^8)/GF(2^4)/GF(2^2).
//   MODE=0 : raw multiplicative inverse in tower normal basis (1 == 8'hFF)
//   MODE=1 : AES forward S-box (basis change + inverse + affine)
// Optional macro GF256_INV_SBOX_DEC_EN adds port in_dec, selecting the inverse
// S-box per beat (MODE=1 only). Without it the engine is forward-only.
module gf256_inv_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 4,
  parameter int MODE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef GF256_INV_SBOX_DEC_EN
  input  logic               in_dec,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  // Basis-change matrices: byte j (counted from the LSB) is the image of input bit j.
  // X2S folds the AES affine matrix in; S2X folds the inverse affine matrix in.
  localparam logic [63:0] A2X = 64'h98F3_F248_0981_A9FF;
  localparam logic [63:0] X2S = 64'h582D_9E0B_DC04_0324;
  localparam logic [63:0] S2X = 64'h8C79_05EB_1204_5153;
  localparam logic [63:0] X2A = 64'h6478_6E8C_6829_DE60;

  // GF(2^2) arithmetic, normal basis (W^2, W)
  function automatic logic [1:0] g4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] g4_sq(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [1:0] g4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [1:0] g4_scl_n2(input logic [1:0] x);
    return {x[1] ^ x[0], x[1]};
  endfunction

  // GF(2^4) arithmetic, normal basis (A^8, A^2)
  function automatic logic [3:0] g16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    e = g4_scl_n(g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {g4_mul(x[3:2], y[3:2]) ^ e, g4_mul(x[1:0], y[1:0]) ^ e};
  endfunction

  // Square and scale by nu, the norm constant of the GF(2^8) level
  function automatic logic [3:0] g16_sq_scl(input logic [3:0] x);
    return {g4_sq(x[3:2] ^ x[1:0]), g4_scl_n2(g4_sq(x[1:0]))};
  endfunction

  // Inverse via GF(2^2); the GF(2^2) inverse equals the square
  function automatic logic [3:0] g16_inv(input logic [3:0] x);
    logic [1:0] c, d, e;
    c = g4_scl_n(g4_sq(x[3:2] ^ x[1:0]));
    d = g4_mul(x[3:2], x[1:0]);
    e = g4_sq(c ^ d);
    return {g4_mul(e, x[1:0]), g4_mul(e, x[3:2])};
  endfunction

  function automatic logic [7:0] basis(input logic [7:0] x, input logic [63:0] m);
    logic [7:0] y;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      if (x[j]) y = y ^ m[8*j +: 8];
    end
    return y;
  endfunction

  logic                 vld_p1_q, vld_p2_q, vld_p3_q;
  logic                 en1, en2, en3;
  logic [4*LANES-1:0]   a_p1_q, b_p1_q, d_p1_q, a_p1_d, b_p1_d, d_p1_d;
  logic [4*LANES-1:0]   a_p2_q, b_p2_q, dinv_p2_q, dinv_p2_d;
  logic [8*LANES-1:0]   out_data_q, out_data_d;
  logic [TAG_W-1:0]     tag_p1_q, tag_p2_q, out_tag_q;
  logic                 dec_s1, dec_s3;

`ifdef GF256_INV_SBOX_DEC_EN
  logic dec_p1_q, dec_p2_q;
  assign dec_s1 = in_dec;
  assign dec_s3 = dec_p2_q;
`else
  assign dec_s1 = 1'b0;
  assign dec_s3 = 1'b0;
`endif

  assign en3       = !vld_p3_q | out_ready;
  assign en2       = !vld_p2_q | en3;
  assign en1       = !vld_p1_q | en2;
  assign in_ready  = en1;
  assign out_valid = vld_p3_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign busy      = vld_p1_q | vld_p2_q | vld_p3_q;

  // Stage 1: input basis change, split into nibbles, norm term d = ab + nu(a+b)^2
  always_comb begin
    logic [7:0] x;
    logic [3:0] hi, lo;
    x = '0; hi = '0; lo = '0;
    a_p1_d = '0; b_p1_d = '0; d_p1_d = '0;
    for (int k = 0; k < LANES; k++) begin
      x = in_data[8*k +: 8];
      if (MODE != 0) x = dec_s1 ? basis(x ^ 8'h63, S2X) : basis(x, A2X);
      hi = x[7:4];
      lo = x[3:0];
      a_p1_d[4*k +: 4] = hi;
      b_p1_d[4*k +: 4] = lo;
      d_p1_d[4*k +: 4] = g16_mul(hi, lo) ^ g16_sq_scl(hi ^ lo);
    end
  end

  // Stage 2: GF(2^4) inverse of the norm term
  always_comb begin
    dinv_p2_d = '0;
    for (int k = 0; k < LANES; k++) begin
      dinv_p2_d[4*k +: 4] = g16_inv(d_p1_q[4*k +: 4]);
    end
  end

  // Stage 3: recombine {dinv*b, dinv*a}, then output basis change (+ affine)
  always_comb begin
    logic [7:0] y;
    logic [3:0] di;
    y = '0; di = '0;
    out_data_d = '0;
    for (int k = 0; k < LANES; k++) begin
      di = dinv_p2_q[4*k +: 4];
      y  = {g16_mul(di, b_p2_q[4*k +: 4]), g16_mul(di, a_p2_q[4*k +: 4])};
      if (MODE != 0) y = dec_s3 ? basis(y, X2A) : (basis(y, X2S) ^ 8'h63);
      out_data_d[8*k +: 8] = y;
    end
  end

  // Pipeline registers: each stage loads when its enable is high; reset clears everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      a_p1_q     <= '0;
      b_p1_q     <= '0;
      d_p1_q     <= '0;
      tag_p1_q   <= '0;
      a_p2_q     <= '0;
      b_p2_q     <= '0;
      dinv_p2_q  <= '0;
      tag_p2_q   <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
`ifdef GF256_INV_SBOX_DEC_EN
      dec_p1_q   <= 1'b0;
      dec_p2_q   <= 1'b0;
`endif
    end else begin
      if (en1) begin
        vld_p1_q <= in_valid;
        a_p1_q   <= a_p1_d;
        b_p1_q   <= b_p1_d;
        d_p1_q   <= d_p1_d;
        tag_p1_q <= in_tag;
`ifdef GF256_INV_SBOX_DEC_EN
        dec_p1_q <= in_dec;
`endif
      end
      if (en2) begin
        vld_p2_q  <= vld_p1_q;
        a_p2_q    <= a_p1_q;
        b_p2_q    <= b_p1_q;
        dinv_p2_q <= dinv_p2_d;
        tag_p2_q  <= tag_p1_q;
`ifdef GF256_INV_SBOX_DEC_EN
        dec_p2_q  <= dec_p1_q;
`endif
      end
      if (en3) begin
        vld_p3_q   <= vld_p2_q;
        out_data_q <= out_data_d;
        out_tag_q  <= tag_p2_q;
      end
    end
  end

endmodule

// File: tb/tb_gf256_inv_pipe.sv
// Testbench for gf256_inv_pipe: an AES S-box instance (MODE=1) and a raw
// inverter instance (MODE=0) share stimulus. Expected S-box values come from a
// polynomial-basis AES model; raw inverses are checked as x*inv(x) == 8'hFF
// with an independent normal-basis tower multiplier.
module tb_gf256_inv_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_dec = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_tag = '0;

  logic        s_in_ready, s_out_valid, s_busy;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_tag;
  logic        r_in_ready, r_out_valid, r_busy;
  logic [31:0] r_out_data;
  logic [3:0]  r_out_tag;

  int n_chk = 0;
  int n_err = 0;
  int retired = 0;
  int both = 0;
  int cyc = 0;

  logic [7:0]  sbox_tbl [256];
  logic [7:0]  isbox_tbl[256];
  logic [31:0] q_d[$];
  logic [3:0]  q_t[$];
  logic        q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf256_inv_pipe #(.LANES(4), .TAG_W(4), .MODE(1)) u_sbox (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_tag(in_tag),
`ifdef GF256_INV_SBOX_DEC_EN
    .in_dec(in_dec),
`endif
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_tag(s_out_tag), .busy(s_busy));

  gf256_inv_pipe #(.LANES(4), .TAG_W(4), .MODE(0)) u_raw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_data(in_data), .in_tag(in_tag),
`ifdef GF256_INV_SBOX_DEC_EN
    .in_dec(in_dec),
`endif
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .out_tag(r_out_tag), .busy(r_busy));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // AES polynomial-basis reference
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Normal-basis tower multiplier: GF(4) basis (W^2,W), N = W^2 = 2'b10; nu = 4'h1
  function automatic logic [1:0] m4(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [3:0] m16(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    e = m4(m4(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]), 2'b10);
    return {m4(x[3:2], y[3:2]) ^ e, m4(x[1:0], y[1:0]) ^ e};
  endfunction

  function automatic logic [7:0] m256(input logic [7:0] x, input logic [7:0] y);
    logic [3:0] e;
    e = m16(m16(x[7:4] ^ x[3:0], y[7:4] ^ y[3:0]), 4'h1);
    return {m16(x[7:4], y[7:4]) ^ e, m16(x[3:0], y[3:0]) ^ e};
  endfunction

  function automatic logic [31:0] ref_s(input logic [31:0] d, input logic dc);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = dc ? isbox_tbl[d[8*k +: 8]] : sbox_tbl[d[8*k +: 8]];
    return r;
  endfunction

  // Scoreboard: records accepted beats, checks each retired beat in order
  always @(negedge clk) begin
    logic [31:0] d;
    logic [3:0]  t;
    logic        dc;
    logic [7:0]  x, y;
    if (!rst_n) begin
      q_d.delete(); q_t.delete(); q_c.delete();
    end else begin
      if (s_out_valid && out_ready) begin
        chk("sb_nonempty", 64'(q_d.size() != 0), 64'd1);
        if (q_d.size() != 0) begin
          d = q_d.pop_front(); t = q_t.pop_front(); dc = q_c.pop_front();
          chk("sb_tag", 64'(s_out_tag), 64'(t));
          chk("sb_sbox", 64'(s_out_data), 64'(ref_s(d, dc)));
          chk("sb_rawvld", 64'(r_out_valid), 64'd1);
          chk("sb_rawtag", 64'(r_out_tag), 64'(t));
          for (int k = 0; k < 4; k++) begin
            x = d[8*k +: 8];
            y = r_out_data[8*k +: 8];
            if (x == 8'h00) chk("raw_zero", 64'(y), 64'd0);
            else chk("raw_inv", 64'(m256(x, y)), 64'hFF);
          end
          retired++;
          if (in_valid && s_in_ready) both++;
        end
      end
      if (in_valid && s_in_ready) begin
        q_d.push_back(in_data); q_t.push_back(in_tag); q_c.push_back(in_dec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted; returns just after the accepting edge
  task automatic push(input logic [31:0] d, input logic [3:0] t, input logic dc);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_tag = t; in_dec = dc;
    @(negedge clk);
    while (!s_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 64'(s_in_ready), 64'd1);
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q_d.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q_d.size()), 64'd0);
    tick();
  endtask

  task automatic vec(input string nm, input logic [31:0] d, input logic [3:0] t, input logic dc,
                     input logic [31:0] exp_s, input logic [31:0] exp_r, input bit use_r);
    push(d, t, dc);
    in_valid = 1'b0;
    @(negedge clk); chk({nm, "_lat1"}, 64'(s_out_valid), 64'd0);
    @(negedge clk); chk({nm, "_lat2"}, 64'(s_out_valid), 64'd0);
    @(negedge clk);
    chk({nm, "_vld"},  64'(s_out_valid), 64'd1);
    chk({nm, "_data"}, 64'(s_out_data), 64'(exp_s));
    chk({nm, "_tag"},  64'(s_out_tag), 64'(t));
    if (use_r) chk({nm, "_raw"}, 64'(r_out_data), 64'(exp_r));
    @(negedge clk);
    chk({nm, "_idle"}, 64'({s_busy, s_out_valid}), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, b0, r0;
    logic [7:0] iv;
    logic [31:0] held;
    bit have;

    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (pmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      sbox_tbl[x] = affine(iv);
    end
    for (int x = 0; x < 256; x++) isbox_tbl[sbox_tbl[x]] = 8'(x);

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  64'(s_in_ready), 64'd1);
    chk("rst_out_valid", 64'(s_out_valid), 64'd0);
    chk("rst_busy",      64'(s_busy), 64'd0);
    chk("rst_out_data",  64'(s_out_data), 64'd0);
    chk("rst_out_tag",   64'(s_out_tag), 64'd0);
    tick();

    // Directed vectors (hand-derived from the AES S-box table)
    vec("v53", 32'h5301_00C9, 4'h5, 1'b0, 32'hED7C_63DD, 32'h0, 1'b0);
    vec("vff", 32'h00FF_00FF, 4'hA, 1'b0, 32'h6316_6316, 32'h00FF_00FF, 1'b1);
    vec("v10", 32'h1080_0203, 4'hC, 1'b0, 32'hCACD_777B, 32'h0, 1'b0);

    // All 256 byte values, four per beat, back to back
    for (int i = 0; i < 64; i++)
      push({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'(i), 1'b0);
    in_valid = 1'b0;
    drain();

    // Backpressure: 8 tagged beats with a 5-cycle output stall
    r0 = retired;
    fork
      begin
        for (int t = 0; t < 8; t++) push(32'h1122_3344 + 32'(t) * 32'h0101_0101, 4'(t), 1'b0);
        in_valid = 1'b0;
      end
      begin
        have = 1'b0; held = '0;
        tick(); tick();
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (s_out_valid) begin
            if (have) chk("stall_hold", 64'(s_out_data), 64'(held));
            else begin held = s_out_data; have = 1'b1; end
          end
        end
        chk("stall_in_ready", 64'(s_in_ready), 64'd0);
        chk("stall_tag",      64'(s_out_tag), 64'd0);
        chk("stall_data",     64'(s_out_data), 64'(ref_s(32'h1122_3344, 1'b0)));
        tick();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(retired - r0), 64'd8);

    // Throughput: 100 random beats, accept and retire together when full
    r0 = retired; b0 = both; c0 = cyc;
    for (int i = 0; i < 100; i++) push($urandom, 4'(i), 1'b0);
    in_valid = 1'b0;
    chk("tput_cycles", 64'(cyc - c0), 64'd100);
    drain();
    chk("tput_overlap", 64'(both - b0), 64'd97);
    chk("tput_count",   64'(retired - r0), 64'd100);

    // Reset with all three stages occupied
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) push(32'hA5A5_A5A5 ^ 32'(t), 4'(t), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("prerst_full", 64'({s_busy, s_out_valid, s_in_ready}), 64'b110);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 64'(s_out_valid), 64'd0);
    chk("mrst_busy",      64'(s_busy), 64'd0);
    chk("mrst_out_data",  64'(s_out_data), 64'd0);
    chk("mrst_out_tag",   64'(s_out_tag), 64'd0);
    chk("mrst_in_ready",  64'(s_in_ready), 64'd1);
    tick();
    vec("post_rst", 32'h0000_0001, 4'h9, 1'b0, 32'h6363_637C, 32'h0, 1'b0);

`ifdef GF256_INV_SBOX_DEC_EN
    // Inverse S-box and per-beat mode selection
    vec("dec", 32'hED7C_63DD, 4'h3, 1'b1, 32'h5301_00C9, 32'h0, 1'b0);
    r0 = retired;
    for (int i = 0; i < 8; i++) push(32'h3C5A_96E1 + 32'(i) * 32'h1357_9BDF, 4'(i), i[0]);
    in_valid = 1'b0;
    drain();
    chk("dec_count", 64'(retired - r0), 64'd8);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
